// File: rtl/register_file_pkg.sv
// Shared register-file constants and index type for the pipeline stages.
package register_file_pkg;

  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_ADDR_WIDTH = 4;

  typedef logic [RF_ADDR_WIDTH-1:0] reg_idx_t;

endpackage : register_file_pkg

// File: rtl/register_file_bypass.sv
// One read port's write-through mux; reads are forced to zero while reset is held.
module register_file_bypass #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] src_i,
  input  logic [ADDR_WIDTH-1:0] dest_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  always_comb begin
    data_o = rdata_i;
    if (!rst_n_i) begin
      data_o = '0;
    end else if (we_i && (dest_i == src_i)) begin
      data_o = wdata_i;
    end
  end

endmodule : register_file_bypass

// File: rtl/register_file.sv
// 2-read / 1-write general-purpose register file with write-through bypass.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] src1,
  input  logic [ADDR_WIDTH-1:0] src2,
  input  logic [ADDR_WIDTH-1:0] Dest_wb,
  input  logic [DATA_WIDTH-1:0] Result_WB,
  input  logic                  writeBackEn,
  output logic [DATA_WIDTH-1:0] reg1,
  output logic [DATA_WIDTH-1:0] reg2
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (writeBackEn) begin
      regs_d[Dest_wb] = Result_WB;
    end
  end

  // Reset is active-low and asynchronous; it also masks any coincident write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  register_file_bypass #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bypass1 (
    .rst_n_i (rst),
    .we_i    (writeBackEn),
    .src_i   (src1),
    .dest_i  (Dest_wb),
    .wdata_i (Result_WB),
    .rdata_i (regs_q[src1]),
    .data_o  (reg1)
  );

  register_file_bypass #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bypass2 (
    .rst_n_i (rst),
    .we_i    (writeBackEn),
    .src_i   (src2),
    .dest_i  (Dest_wb),
    .wdata_i (Result_WB),
    .rdata_i (regs_q[src2]),
    .data_o  (reg2)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed and randomized checks of register_file (4-bit data, 4 registers) against an array model.
module tb_register_file;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 2;

  logic          clk;
  logic          rst;
  logic [AW-1:0] src1, src2, dest;
  logic [DW-1:0] wd;
  logic          we;
  logic [DW-1:0] reg1, reg2;

  int unsigned   n_cmp;
  int unsigned   n_err;
  logic [DW-1:0] model [4];

  register_file #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src1        (src1),
    .src2        (src2),
    .Dest_wb     (dest),
    .Result_WB   (wd),
    .writeBackEn (we),
    .reg1        (reg1),
    .reg2        (reg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference read: zero in reset, in-flight write wins, otherwise stored value.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] idx);
    if (!rst) return '0;
    if (we && dest == idx) return wd;
    return model[idx];
  endfunction

  task automatic check_out(input string tag);
    chk({tag, "_reg1"}, reg1, exp_rd(src1));
    chk({tag, "_reg2"}, reg2, exp_rd(src2));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) model[i] = '0;
  endtask

  // Called at a falling edge; checks before and after the next rising edge.
  task automatic cycle(input string tag);
    #2 check_out({tag, "_pre"});
    @(posedge clk);
    if (rst && we) model[dest] = wd;
    #1 check_out({tag, "_post"});
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; we = 1'b0; wd = '0; dest = '0; src1 = '0; src2 = '0;
    clear_model();
    @(negedge clk);

    // Reset held with an active write request
    we = 1'b1; wd = 4'b1011; dest = 2'd0; src1 = 2'd0; src2 = 2'd1;
    for (int i = 0; i < 5; i++) begin
      cycle("rst_hold");
      chk("rst_hold_r1_zero", reg1, 4'b0000);
      chk("rst_hold_r2_zero", reg2, 4'b0000);
    end
    rst = 1'b1; we = 1'b0;
    cycle("rst_release");
    src1 = 2'd0; src2 = 2'd1;
    #2 chk("rel_r0", reg1, 4'b0000); chk("rel_r1", reg2, 4'b0000);
    src1 = 2'd2; src2 = 2'd3;
    #1 chk("rel_r2", reg1, 4'b0000); chk("rel_r3", reg2, 4'b0000);
    @(negedge clk);

    // Write with bypass
    dest = 2'd0; we = 1'b1; wd = 4'b1011; src1 = 2'd0; src2 = 2'd1;
    #2 chk("byp_pre_r1", reg1, 4'b1011); chk("byp_pre_r2", reg2, 4'b0000);
    @(negedge clk);
    cycle("wr0");
    chk("wr0_r1", reg1, 4'b1011);
    chk("wr0_r2", reg2, 4'b0000);
    dest = 2'd1;
    cycle("wr1");
    chk("wr1_r2", reg2, 4'b1011);

    // Writes disabled
    we = 1'b0; wd = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      cycle("wdis");
      chk("wdis_r1", reg1, 4'b1011);
      chk("wdis_r2", reg2, 4'b1011);
    end
    src1 = 2'd2; src2 = 2'd3;
    cycle("wdis_rd23");
    chk("wdis_r2_zero", reg1, 4'b0000);
    chk("wdis_r3_zero", reg2, 4'b0000);

    // Later writes
    we = 1'b1; dest = 2'd2; wd = 4'b0101;
    cycle("wr2");
    chk("wr2_r1", reg1, 4'b0101);
    dest = 2'd3;
    cycle("wr3");
    chk("wr3_r2", reg2, 4'b0101);
    we = 1'b0; src1 = 2'd0; src2 = 2'd1;
    cycle("reread");
    chk("reread_r1", reg1, 4'b1011);
    chk("reread_r2", reg2, 4'b1011);

    // Same index on both read ports and the write port
    src1 = 2'd3; src2 = 2'd3; dest = 2'd3; we = 1'b1; wd = 4'b1110;
    #2 chk("same_pre_r1", reg1, 4'b1110); chk("same_pre_r2", reg2, 4'b1110);
    @(negedge clk);
    cycle("same");
    we = 1'b0;
    #2 chk("same_post_r1", reg1, 4'b1110); chk("same_post_r2", reg2, 4'b1110);
    @(negedge clk);

    // Asynchronous reset between edges
    src1 = 2'd0; src2 = 2'd3;
    #2 chk("pre_arst_r1", reg1, 4'b1011); chk("pre_arst_r2", reg2, 4'b1110);
    rst = 1'b0;
    clear_model();
    #1 chk("arst_r1", reg1, 4'b0000); chk("arst_r2", reg2, 4'b0000);
    @(posedge clk);
    #1 check_out("arst_edge");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i += 2) begin
      src1 = 2'(i); src2 = 2'(i + 1);
      cycle("arst_readback");
      chk("arst_rb_r1", reg1, 4'b0000);
      chk("arst_rb_r2", reg2, 4'b0000);
    end

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 300; i++) begin
      src1 = 2'($urandom_range(0, 3));
      src2 = 2'($urandom_range(0, 3));
      dest = 2'($urandom_range(0, 3));
      wd   = 4'($urandom_range(0, 15));
      we   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        #2 rst = 1'b0;
        clear_model();
        #1 check_out("rnd_arst");
        @(posedge clk);
        #1 check_out("rnd_arst_edge");
        @(negedge clk);
        rst = 1'b1;
      end else begin
        cycle("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_register_file

// File: doc/register_file.md
Name: register_file

Overview:
- Parameterised multi-ported general-purpose register file for the pipelined CPU.
- Two combinational read ports are consumed by the decode stage.
- One synchronous write port is driven by the write-back stage.
- Write-through bypass: a write-back in the current cycle is visible to decode in the same cycle.

Parameters:
- DATA_WIDTH, 32, bit width of each register and of every data port.
- ADDR_WIDTH, 4, register index width; depth = 2**ADDR_WIDTH registers.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 clears all registers immediately.
- src1  input  ADDR_WIDTH  read port 1 register index.
- src2  input  ADDR_WIDTH  read port 2 register index.
- Dest_wb  input  ADDR_WIDTH  write-back destination index.
- Result_WB  input  DATA_WIDTH  write-back data.
- writeBackEn  input  1  write enable, active-high.
- reg1  output  DATA_WIDTH  contents of register src1, after bypass.
- reg2  output  DATA_WIDTH  contents of register src2, after bypass.

Behaviour:
- Storage: array of 2**ADDR_WIDTH registers, each DATA_WIDTH bits; all registers are writable (no hard-wired zero register).
- Reset:
  - rst=0 asynchronously forces every register to 0, independent of clk.
  - While rst=0, writes are ignored and reg1/reg2 read 0, bypass included.
  - Release of rst takes effect at the next rising edge.
- Write:
  - At rising clk with rst=1 and writeBackEn=1, register[Dest_wb] <= Result_WB.
  - With writeBackEn=0, no register changes, whatever Dest_wb or Result_WB do.
- Read:
  - reg1/reg2 are purely combinational from src1/src2 and the array.
  - Zero-cycle latency: a change on src1/src2 is reflected in the same cycle.
- Bypass:
  - If writeBackEn=1 and Dest_wb==src1, reg1 = Result_WB; else reg1 = register[src1].
  - reg2 follows the same rule with src2.
  - Both ports may bypass simultaneously when src1==src2==Dest_wb.
  - After the clock edge the stored value equals the bypassed value, so outputs are glitch-free across the edge apart from input changes.
- Simultaneous events:
  - Same index on both read ports returns identical data on reg1 and reg2.
  - Reset asserted coincident with a write edge: reset wins and the register stays 0.
- Width rules: no arithmetic; indices are always in range, because depth = 2**ADDR_WIDTH.
- No X propagation from reset onward; every register has a defined value.

Decomposition:
- Shared package: default DATA_WIDTH/ADDR_WIDTH constants and a reg_idx_t typedef (ADDR_WIDTH bits) for the pipeline stages.
- No sub-module is required. The single-port bypass mux may optionally be factored as register_file_bypass and instantiated once per read port.

Test Plan (DATA_WIDTH=4, ADDR_WIDTH=2):
- Reset: hold rst=0 for 5 cycles with writeBackEn=1, Result_WB=4'b1011 -> reg1=reg2=0 throughout; after release, all four registers read 0.
- Write and bypass: rst=1, Dest_wb=0, writeBackEn=1, Result_WB=4'b1011, src1=0, src2=1 -> reg1=1011 before the edge (bypass) and after it; reg2=0. Then Dest_wb=1 -> reg2=1011 after the edge.
- Write disabled: writeBackEn=0, Result_WB=4'b0101 for 3 cycles -> reg1=reg2=1011 unchanged. Then src1=2, src2=3 -> reg1=reg2=0.
- Later writes: writeBackEn=1, Dest_wb=2 then Dest_wb=3 with data 0101 -> reg1=0101, then reg2=0101. Re-read src1=0, src2=1 -> 1011 on both.
- Same-index read: src1=src2=Dest_wb=3, write 4'b1110 -> reg1=reg2=1110 in the same cycle and after the edge.
- Mid-operation reset: assert rst=0 between clock edges after registers are loaded -> reg1=reg2=0 immediately, without waiting for clk. After release, all registers read 0.
